// File: rtl/countdown_sequencer.sv
// Countdown sequencer: BCD mm:ss timer controlled by add/sub/start/stop buttons.
// Runs down once per prescaler tick, raises an alarm at 00:00, and then
// auto-clears the alarm after ALARM_SECS ticks.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | stopped; minutes adjustable; start runs if time nonzero
// S_RUN   | counting down one second per tick
// S_PAUSE | time frozen; minutes adjustable; start resumes, stop clears
// S_ALARM | time is 00:00; alarm held for ALARM_SECS ticks or until ack
module countdown_sequencer #(
    parameter int TICK_DIV   = 50000000,
    parameter int ALARM_SECS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        add,
    input  logic        sub,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] out_final,
    output logic        running,
    output logic        paused,
    output logic        alarm,
    output logic        tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(TICK_DIV - 1);
    localparam logic [7:0]    ALARM_TC = 8'(ALARM_SECS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ALARM} state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  presc, presc_nxt;
    logic [7:0]     alarm_cnt, alarm_cnt_nxt;
    logic [15:0]    time_nxt;
    logic           add_q, sub_q, start_q, stop_q;
    logic           add_e, sub_e, start_e, stop_e;
    logic           tc_hit;

    // Minutes +1 in BCD, saturating at 99; seconds untouched.
    function automatic logic [15:0] min_inc(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[15:8] == 8'h99)
            r = t;
        else if (t[11:8] == 4'd9) begin
            r[11:8]  = 4'd0;
            r[15:12] = t[15:12] + 4'd1;
        end else
            r[11:8] = t[11:8] + 4'd1;
        return r;
    endfunction

    // Minutes -1 in BCD, saturating at 00; seconds untouched.
    function automatic logic [15:0] min_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[15:8] == 8'h00)
            r = t;
        else if (t[11:8] == 4'd0) begin
            r[11:8]  = 4'd9;
            r[15:12] = t[15:12] - 4'd1;
        end else
            r[11:8] = t[11:8] - 4'd1;
        return r;
    endfunction

    // One-second BCD decrement; only called with a time above 00:01.
    function automatic logic [15:0] sec_dec(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        if (t[3:0] != 4'd0)
            r[3:0] = t[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (t[7:4] != 4'd0)
                r[7:4] = t[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (t[11:8] != 4'd0)
                    r[11:8] = t[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = t[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    assign add_e   = add   & ~add_q;
    assign sub_e   = sub   & ~sub_q;
    assign start_e = start & ~start_q;
    assign stop_e  = stop  & ~stop_q;
    assign tc_hit  = ((state == S_RUN) || (state == S_ALARM)) && (presc == PRESC_TC);

    // Next-state, next-time and counter decisions; stop has priority over start and tick.
    always_comb begin
        state_nxt     = state;
        time_nxt      = out_final;
        alarm_cnt_nxt = alarm_cnt;
        case (state)
            S_IDLE: begin
                if (stop_e) begin
                    state_nxt = S_IDLE;
                end else if (start_e) begin
                    if (out_final != 16'h0000)
                        state_nxt = S_RUN;
                end else if (add_e && !sub_e)
                    time_nxt = min_inc(out_final);
                else if (sub_e && !add_e)
                    time_nxt = min_dec(out_final);
            end
            S_PAUSE: begin
                if (stop_e) begin
                    state_nxt = S_IDLE;
                    time_nxt  = 16'h0000;
                end else if (start_e)
                    state_nxt = S_RUN;
                else if (add_e && !sub_e)
                    time_nxt = min_inc(out_final);
                else if (sub_e && !add_e)
                    time_nxt = min_dec(out_final);
            end
            S_RUN: begin
                if (stop_e)
                    state_nxt = S_PAUSE;
                else if (tc_hit) begin
                    if (out_final <= 16'h0001) begin
                        time_nxt  = 16'h0000;
                        state_nxt = S_ALARM;
                    end else
                        time_nxt = sec_dec(out_final);
                end
            end
            S_ALARM: begin
                time_nxt = 16'h0000;
                if (start_e || stop_e)
                    state_nxt = S_IDLE;
                else if (tc_hit) begin
                    if (alarm_cnt == ALARM_TC)
                        state_nxt = S_IDLE;
                    else
                        alarm_cnt_nxt = alarm_cnt + 8'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Counters restart on every state change; prescaler idles outside RUN/ALARM.
        if (state_nxt != state)
            alarm_cnt_nxt = 8'd0;
        if ((state_nxt != state) || !((state == S_RUN) || (state == S_ALARM)) || tc_hit)
            presc_nxt = '0;
        else
            presc_nxt = presc + PW'(1);
    end

    // State, time, counters, edge history and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            out_final <= 16'h0000;
            presc     <= '0;
            alarm_cnt <= 8'd0;
            add_q     <= 1'b0;
            sub_q     <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            running   <= 1'b0;
            paused    <= 1'b0;
            alarm     <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_final <= time_nxt;
            presc     <= presc_nxt;
            alarm_cnt <= alarm_cnt_nxt;
            add_q     <= add;
            sub_q     <= sub;
            start_q   <= start;
            stop_q    <= stop;
            running   <= (state_nxt == S_RUN);
            paused    <= (state_nxt == S_PAUSE);
            alarm     <= (state_nxt == S_ALARM);
            tick      <= tc_hit;
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer with TICK_DIV=4, ALARM_SECS=2.
// Expected output bundles {tick, alarm, paused, running, out_final} are queued
// when stimulus is applied and popped when the DUT result is due.
module tb_countdown_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        add = 1'b0, sub = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] out_final;
    logic        running, paused, alarm, tick;

    logic [19:0] sb_q[$];
    string       sb_n[$];
    logic [19:0] exp_v, obs_v;
    string       nm;
    int          n_cmp = 0;
    int          n_err = 0;

    countdown_sequencer #(.TICK_DIV(4), .ALARM_SECS(2)) dut (
        .clk(clk), .reset_n(reset_n), .add(add), .sub(sub), .start(start), .stop(stop),
        .out_final(out_final), .running(running), .paused(paused), .alarm(alarm), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mask bits: 0 add, 1 sub, 2 start, 3 stop; held for exactly one edge
    task automatic pulse(input logic [3:0] mask);
        {stop, start, sub, add} = mask;
        step();
        {stop, start, sub, add} = 4'b0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        sb_q.push_back(20'h0_0000); sb_n.push_back("reset_hold");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        reset_n = 1'b1;
        step();
        sb_q.push_back(20'h0_0000); sb_n.push_back("reset_release");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
    endtask

    task automatic test_first_tick();
        repeat (3) begin pulse(4'b0001); step(); end
        sb_q.push_back({4'b0000, 16'h0300}); sb_n.push_back("load_3min");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        pulse(4'b0100);
        sb_q.push_back({4'b0001, 16'h0300}); sb_n.push_back("run_entry");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        repeat (3) step();
        sb_q.push_back({4'b0001, 16'h0300}); sb_n.push_back("pre_tick");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        sb_q.push_back({4'b1001, 16'h0259}); sb_n.push_back("first_tick");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        sb_q.push_back({4'b0001, 16'h0259}); sb_n.push_back("tick_one_cycle");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
    endtask

    task automatic test_alarm_timeout();
        pulse(4'b1000);
        sb_q.push_back({4'b0010, 16'h0259}); sb_n.push_back("pause_0259");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b1000);
        sb_q.push_back(20'h0_0000); sb_n.push_back("pause_stop_clear");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0001); step();
        pulse(4'b0100);
        for (int k = 1; k <= 60; k++) begin
            if (k < 60) sb_q.push_back({4'b1001, to_bcd(60 - k)});
            else        sb_q.push_back({4'b1100, 16'h0000});
            sb_n.push_back($sformatf("countdown_tick_%0d", k));
            repeat (4) step();
            exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
            if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        end
        repeat (3) step();
        sb_q.push_back({4'b0100, 16'h0000}); sb_n.push_back("alarm_hold");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        sb_q.push_back({4'b1100, 16'h0000}); sb_n.push_back("alarm_tick_1");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        repeat (4) step();
        sb_q.push_back({4'b1000, 16'h0000}); sb_n.push_back("alarm_auto_clear");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
    endtask

    task automatic test_saturation();
        pulse(4'b0010);
        sb_q.push_back(20'h0_0000); sb_n.push_back("sub_at_zero");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0100);
        sb_q.push_back(20'h0_0000); sb_n.push_back("start_at_zero");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        repeat (99) begin pulse(4'b0001); step(); end
        sb_q.push_back({4'b0000, 16'h9900}); sb_n.push_back("add_to_99");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        pulse(4'b0001);
        sb_q.push_back({4'b0000, 16'h9900}); sb_n.push_back("add_saturate");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0010);
        sb_q.push_back({4'b0000, 16'h9800}); sb_n.push_back("sub_from_99");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0100); step();
        pulse(4'b1000);
        sb_q.push_back({4'b0010, 16'h9800}); sb_n.push_back("pause_9800");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0010);
        sb_q.push_back({4'b0010, 16'h9700}); sb_n.push_back("sub_in_pause");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b1000); step();
    endtask

    task automatic test_pause_resume();
        repeat (10) begin pulse(4'b0001); step(); end
        sb_q.push_back({4'b0000, 16'h1000}); sb_n.push_back("add_carry_1000");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        pulse(4'b0100); step(); step();
        pulse(4'b1000);
        sb_q.push_back({4'b0010, 16'h1000}); sb_n.push_back("pause_1000");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        sb_q.push_back({4'b0010, 16'h1000}); sb_n.push_back("pause_frozen");
        repeat (20) step();
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        pulse(4'b0100);
        sb_q.push_back({4'b0001, 16'h1000}); sb_n.push_back("resume");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        repeat (4) step();
        sb_q.push_back({4'b1001, 16'h0959}); sb_n.push_back("resume_borrow_0959");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        pulse(4'b1000);
        sb_q.push_back({4'b0010, 16'h0959}); sb_n.push_back("pause_0959");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0010);
        sb_q.push_back({4'b0010, 16'h0859}); sb_n.push_back("sub_keeps_secs");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b1000);
        sb_q.push_back(20'h0_0000); sb_n.push_back("second_stop_idle");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
    endtask

    task automatic test_simultaneous();
        pulse(4'b0001); step();
        pulse(4'b0011);
        sb_q.push_back({4'b0000, 16'h0100}); sb_n.push_back("add_sub_same_cycle");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0100);
        repeat (3) step();
        pulse(4'b1000);
        sb_q.push_back({4'b1010, 16'h0100}); sb_n.push_back("stop_beats_tick");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b1100);
        sb_q.push_back(20'h0_0000); sb_n.push_back("stop_beats_start");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
    endtask

    task automatic test_alarm_ack();
        pulse(4'b0001); step();
        pulse(4'b0100);
        repeat (240) step();
        sb_q.push_back({4'b1100, 16'h0000}); sb_n.push_back("alarm_entry");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        pulse(4'b0100);
        sb_q.push_back(20'h0_0000); sb_n.push_back("alarm_ack_start");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
    endtask

    task automatic test_async_reset();
        pulse(4'b0001); step();
        pulse(4'b0100); step(); step();
        #3 reset_n = 1'b0;
        add = 1'b1;
        #1;
        sb_q.push_back(20'h0_0000); sb_n.push_back("async_reset_midrun");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        #2 reset_n = 1'b1;
        step();
        sb_q.push_back({4'b0000, 16'h0100}); sb_n.push_back("held_add_after_reset");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        step();
        sb_q.push_back({4'b0000, 16'h0100}); sb_n.push_back("held_add_single_edge");
        exp_v = sb_q.pop_front(); nm = sb_n.pop_front(); obs_v = {tick, alarm, paused, running, out_final}; n_cmp++;
        if (obs_v !== exp_v) begin n_err++; $display("FAIL %s: got %h expected %h", nm, obs_v, exp_v); end
        add = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_alarm_timeout();
        test_saturation();
        test_pause_resume();
        test_simultaneous();
        test_alarm_ack();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_sequencer.md
COUNTDOWN_SEQUENCER -- requirements
Module: countdown_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per one-second tick (legal range 2..2^26).
REQ-002 SHALL have parameter ALARM_SECS, default 10, seconds the alarm stays asserted before auto-clear (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port add  input  1  button, synchronous to clk; +1 minute on rising edge.
REQ-006 SHALL have port sub  input  1  button, synchronous to clk; -1 minute on rising edge.
REQ-007 SHALL have port start  input  1  button, synchronous to clk; run/resume on rising edge.
REQ-008 SHALL have port stop  input  1  button, synchronous to clk; pause/clear/acknowledge on rising edge.
REQ-009 SHALL have port out_final  output  16  BCD time: [15:12] minutes tens, [11:8] minutes ones, [7:4] seconds tens, [3:0] seconds ones.
REQ-010 SHALL have port running  output  1  high in RUN.
REQ-011 SHALL have port paused  output  1  high in PAUSE.
REQ-012 SHALL have port alarm  output  1  high in ALARM.
REQ-013 SHALL have port tick  output  1  one-cycle pulse on each prescaler terminal count.

Function
REQ-014 SHALL detect button events as rising edges: input high this cycle and registered previous value low; the resulting state/time change is visible after the next clk edge (1-cycle latency).
REQ-015 SHALL implement states IDLE, RUN, PAUSE, ALARM, encoded in a registered FSM.
REQ-016 IDLE/PAUSE: add edge SHALL add 1 minute, saturating at 99:59 minutes field 99 (seconds unchanged); sub edge SHALL subtract 1 minute, saturating at minutes 00 (seconds unchanged).
REQ-017 Simultaneous add and sub edges SHALL be ignored; add/sub SHALL be ignored in RUN and ALARM.
REQ-018 IDLE + start edge with time nonzero SHALL go to RUN; with time 00:00 SHALL stay in IDLE.
REQ-019 RUN + stop edge SHALL go to PAUSE with time held; PAUSE + start edge SHALL go to RUN; PAUSE + stop edge SHALL go to IDLE with time cleared to 00:00.
REQ-020 If start and stop edges coincide, stop SHALL win.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 only in RUN and ALARM, SHALL be cleared to 0 in IDLE/PAUSE and on every state entry; tick SHALL pulse in the cycle the count equals TICK_DIV-1.
REQ-022 In RUN, each tick SHALL decrement time by one second with BCD borrow: seconds ones 0->9 borrowing tens, seconds tens 0->5 borrowing minutes, minutes ones 0->9 borrowing minutes tens.
REQ-023 A tick in RUN at 00:01 SHALL set time 00:00 and enter ALARM on the same edge; no digit SHALL ever hold a non-BCD value or underflow below 00:00.
REQ-024 A stop edge coinciding with a RUN tick SHALL take priority: go to PAUSE, no decrement.
REQ-025 ALARM SHALL hold 00:00, count ALARM_SECS ticks, then return to IDLE; a start or stop edge in ALARM SHALL return to IDLE on the next edge.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, out_final 16'h0000, running/paused/alarm/tick 0, prescaler 0, alarm counter 0, edge-detect registers 0.
REQ-027 Reset asserted mid-RUN or mid-ALARM SHALL abort immediately with the values of REQ-026; a button held high across reset release SHALL register one edge on the first clk after release.

Verification (TICK_DIV=4, ALARM_SECS=2)
REQ-028 Reset, 3 add pulses, start -> out_final 16'h0300, running=1; after 4 clks tick=1 and out_final 16'h0259.
REQ-029 Load 16'h0100, start, run 60 ticks -> 16'h0000, alarm=1 on the tick-60 edge; 2 further ticks -> IDLE, alarm=0.
REQ-030 IDLE at 16'h9900, add -> stays 16'h9900; IDLE at 16'h0000, sub and start -> stays 16'h0000, running=0.
REQ-031 RUN at 16'h1000, stop -> paused=1, value frozen over 20 clks; start -> resumes 16'h0959 after 4 clks; stop twice -> IDLE 16'h0000.
REQ-032 add and sub same cycle -> no change; stop coincident with tick -> PAUSE, no decrement.
REQ-033 reset_n pulsed low between clk edges during RUN -> outputs 0 immediately, before next clk edge.
